// File: rtl/fpnew_pkg.sv
// Shared types for the HUB result buffer: FP status flags and the minimum legal queue depth.
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    localparam int unsigned HUB_RESBUF_MIN_DEPTH = 1;

endpackage

// File: rtl/fpnew_hub_result_fifo.sv
// Generic synchronous FIFO with flush. A push while full is refused even if a pop happens
// in the same cycle, so readiness depends on registered occupancy only.
module fpnew_hub_result_fifo
    import fpnew_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         dtype_t = logic
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  dtype_t                       data_i,
    input  logic                         pop_i,
    output dtype_t                       data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dtype_t           mem_q [DEPTH];
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) r = '0;
        else                        r = p + 1'b1;
        return r;
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rptr_q];

    assign push_ok = push_i & ~full_o  & ~flush_i;
    assign pop_ok  = pop_i  & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_ok) wptr_d = ptr_inc(wptr_q);
            if (pop_ok)  rptr_d = ptr_inc(rptr_q);
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is cleared on reset so the head reads '0 before anything is written.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fpnew_hub_result_buffer.sv
// Records issued tags in order and re-pairs them with in-order HUB slice results.
// Optional combinational bypass when the result FIFO is empty: FPNEW_HUB_RESBUF_BYPASS_EN.
module fpnew_hub_result_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned TagDepth = 4,
    parameter int unsigned ResDepth = 2,
    parameter type         TagType  = logic
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  TagType           tag_i,
    output logic             slice_in_valid_o,
    input  logic             slice_in_ready_i,
    input  logic [Width-1:0] slice_result_i,
    input  status_t          slice_status_i,
    input  logic             slice_ext_bit_i,
    input  logic             slice_out_valid_i,
    output logic             slice_out_ready_o,
    output logic [Width-1:0] result_o,
    output status_t          status_o,
    output logic             extension_bit_o,
    output TagType           tag_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             tag_err_o
);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
    } res_entry_t;

    logic                          tag_full, tag_empty, tag_push, tag_pop;
    logic                          res_full, res_empty, res_push, res_pop;
    logic [$clog2(TagDepth+1)-1:0] tag_used;
    logic [$clog2(ResDepth+1)-1:0] res_used;
    TagType                        tag_head;
    res_entry_t                    res_in, res_head;
    logic                          capture, tag_avail, byp_take, pop;
    logic                          tag_err_q, tag_err_d;

    assign in_ready_o        = slice_in_ready_i & ~tag_full;
    assign slice_in_valid_o  = in_valid_i & ~tag_full;
    assign tag_push          = in_valid_i & in_ready_o;
    assign slice_out_ready_o = ~res_full;
    assign capture           = slice_out_valid_i & slice_out_ready_o;

    // A result needs a tag not already claimed by a queued result; res_used <= tag_used always holds.
    assign tag_avail = (32'(tag_used) > 32'(res_used));

    assign res_in = '{result: slice_result_i, status: slice_status_i, ext_bit: slice_ext_bit_i};

    always_comb begin
        byp_take        = 1'b0;
        out_valid_o     = ~res_empty;
        result_o        = res_head.result;
        status_o        = res_head.status;
        extension_bit_o = res_head.ext_bit;
`ifdef FPNEW_HUB_RESBUF_BYPASS_EN
        if (res_empty && !tag_empty) begin
            out_valid_o     = slice_out_valid_i;
            result_o        = slice_result_i;
            status_o        = slice_status_i;
            extension_bit_o = slice_ext_bit_i;
            byp_take        = slice_out_valid_i & out_ready_i;
        end
`endif
    end

    assign pop      = out_valid_o & out_ready_i;
    assign tag_pop  = pop;
    assign res_pop  = pop & ~byp_take;
    assign res_push = capture & tag_avail & ~byp_take;
    assign tag_o    = tag_head;
    assign busy_o   = ~tag_empty | ~res_empty;

    always_comb begin
        tag_err_d = tag_err_q;
        if (flush_i)                   tag_err_d = 1'b0;
        else if (capture && !tag_avail) tag_err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tag_err_q <= 1'b0;
        else         tag_err_q <= tag_err_d;
    end

    assign tag_err_o = tag_err_q;

    fpnew_hub_result_fifo #(
        .DEPTH   (TagDepth),
        .dtype_t (TagType)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (tag_push),
        .data_i  (tag_i),
        .pop_i   (tag_pop),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .usage_o (tag_used)
    );

    fpnew_hub_result_fifo #(
        .DEPTH   (ResDepth),
        .dtype_t (res_entry_t)
    ) i_res_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (res_push),
        .data_i  (res_in),
        .pop_i   (res_pop),
        .data_o  (res_head),
        .full_o  (res_full),
        .empty_o (res_empty),
        .usage_o (res_used)
    );

endmodule

// File: tb/tb_fpnew_hub_result_buffer.sv
// Directed bench for the HUB result buffer: issue/capture pairing, back-pressure, tag errors, flush.
module tb_fpnew_hub_result_buffer;
    import fpnew_pkg::*;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [3:0]    tag_i;
    logic          slice_in_valid_o;
    logic          slice_in_ready_i;
    logic [31:0]   slice_result_i;
    status_t       slice_status_i;
    logic          slice_ext_bit_i;
    logic          slice_out_valid_i;
    logic          slice_out_ready_o;
    logic [31:0]   result_o;
    status_t       status_o;
    logic          extension_bit_o;
    logic [3:0]    tag_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          busy_o;
    logic          tag_err_o;

    int n_vec = 0;
    int n_err = 0;

    fpnew_hub_result_buffer #(
        .Width    (32),
        .TagDepth (4),
        .ResDepth (2),
        .TagType  (logic [3:0])
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .tag_i             (tag_i),
        .slice_in_valid_o  (slice_in_valid_o),
        .slice_in_ready_i  (slice_in_ready_i),
        .slice_result_i    (slice_result_i),
        .slice_status_i    (slice_status_i),
        .slice_ext_bit_i   (slice_ext_bit_i),
        .slice_out_valid_i (slice_out_valid_i),
        .slice_out_ready_o (slice_out_ready_o),
        .result_o          (result_o),
        .status_o          (status_o),
        .extension_bit_o   (extension_bit_o),
        .tag_o             (tag_o),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .busy_o            (busy_o),
        .tag_err_o         (tag_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    logic [3:0]  exp_tag [3];
    logic [31:0] exp_res [3];
    int          got;
    logic        cap;

    initial begin
        exp_tag = '{4'd1, 4'd2, 4'd3};
        exp_res = '{32'h100, 32'h200, 32'h300};

        rst_ni            = 1'b0;
        flush_i           = 1'b0;
        in_valid_i        = 1'b0;
        tag_i             = '0;
        slice_in_ready_i  = 1'b1;
        slice_result_i    = '0;
        slice_status_i    = '0;
        slice_ext_bit_i   = 1'b0;
        slice_out_valid_i = 1'b0;
        out_ready_i       = 1'b0;

        #12;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tag_err", tag_err_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_slice_out_ready", slice_out_ready_o, 1);

        // Single op: tag 3, result 0x3F800000 one cycle after issue
        cyc(); rst_ni = 1'b1; in_valid_i = 1'b1; tag_i = 4'd3; #2;
        chk("t1_in_ready", in_ready_o, 1);
        chk("t1_slice_in_valid", slice_in_valid_o, 1);
        cyc(); in_valid_i = 1'b0; slice_out_valid_i = 1'b1; slice_result_i = 32'h3F80_0000;
        slice_status_i = 5'b00001; slice_ext_bit_i = 1'b1; #2;
        chk("t1_busy", busy_o, 1);
`ifdef FPNEW_HUB_RESBUF_BYPASS_EN
        chk("t1_valid_same_cycle", out_valid_o, 1);
`else
        chk("t1_valid_same_cycle", out_valid_o, 0);
`endif
        cyc(); slice_out_valid_i = 1'b0; slice_status_i = '0; slice_ext_bit_i = 1'b0; #2;
        chk("t1_out_valid", out_valid_o, 1);
        chk("t1_tag", tag_o, 3);
        chk("t1_result", result_o, 32'h3F80_0000);
        chk("t1_status", status_o, 5'b00001);
        chk("t1_ext", extension_bit_o, 1);
        out_ready_i = 1'b1;
        cyc(); out_ready_i = 1'b0; #2;
        chk("t1_drained_valid", out_valid_o, 0);
        chk("t1_drained_busy", busy_o, 0);

        // Fill the tag queue with 1..4; the 5th attempt is refused
        for (int i = 1; i <= 4; i++) begin
            cyc(); in_valid_i = 1'b1; tag_i = 4'(i); #2;
            chk("t2_issue_ready", in_ready_o, 1);
        end
        cyc(); tag_i = 4'd5; #2;
        chk("t2_full_in_ready", in_ready_o, 0);
        chk("t2_full_slice_in_valid", slice_in_valid_o, 0);
        chk("t2_full_busy", busy_o, 1);

        // Back-pressure: two results fill the FIFO, the third is held
        cyc(); in_valid_i = 1'b0; slice_out_valid_i = 1'b1; slice_result_i = 32'h100; #2;
        chk("t3_ready_0", slice_out_ready_o, 1);
        cyc(); slice_result_i = 32'h200; #2;
        chk("t3_ready_1", slice_out_ready_o, 1);
        cyc(); slice_result_i = 32'h300; #2;
        chk("t3_full_ready", slice_out_ready_o, 0);
        chk("t3_head_valid", out_valid_o, 1);
        chk("t3_head_tag", tag_o, 1);
        cyc(); #2;
        chk("t3_held_ready", slice_out_ready_o, 0);
        chk("t3_held_head", result_o, 32'h100);
        out_ready_i = 1'b1;
        got = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid_o && got < 3) begin
                chk("t3_order_tag", tag_o, exp_tag[got]);
                chk("t3_order_result", result_o, exp_res[got]);
                got++;
            end
            cap = slice_out_valid_i & slice_out_ready_o;
            cyc();
            if (cap) slice_out_valid_i = 1'b0;
            if (got == 3) out_ready_i = 1'b0;
            #2;
            if (got == 3) break;
        end
        chk("t3_order_count", got, 3);
        chk("t3_tag4_left_busy", busy_o, 1);
        chk("t3_tag4_left_valid", out_valid_o, 0);

        // Drain tag 4
        cyc(); slice_out_valid_i = 1'b1; slice_result_i = 32'h400; out_ready_i = 1'b1;
        cyc(); slice_out_valid_i = 1'b0;
        cyc(); out_ready_i = 1'b0; #2;
        chk("t3_drain_busy", busy_o, 0);

        // Result arriving with no outstanding tag (same-cycle issue does not count)
        cyc(); in_valid_i = 1'b1; tag_i = 4'd5; slice_out_valid_i = 1'b1; slice_result_i = 32'hDEAD; #2;
        chk("t4_err_before", tag_err_o, 0);
        cyc(); in_valid_i = 1'b0; slice_out_valid_i = 1'b0; #2;
        chk("t4_err_set", tag_err_o, 1);
        chk("t4_dropped_valid", out_valid_o, 0);
        chk("t4_tag_busy", busy_o, 1);
        cyc(); #2;
        chk("t4_err_sticky", tag_err_o, 1);

        // Flush with 2 tags and 1 result queued; same-cycle issue discarded
        in_valid_i = 1'b1; tag_i = 4'd6;
        cyc(); in_valid_i = 1'b0; slice_out_valid_i = 1'b1; slice_result_i = 32'h500;
        cyc(); slice_out_valid_i = 1'b0; #2;
        chk("t5_pre_valid", out_valid_o, 1);
        chk("t5_pre_tag", tag_o, 5);
        chk("t5_pre_result", result_o, 32'h500);
        chk("t5_pre_err", tag_err_o, 1);
        flush_i = 1'b1; in_valid_i = 1'b1; tag_i = 4'd8;
        cyc(); flush_i = 1'b0; in_valid_i = 1'b0; #2;
        chk("t5_post_busy", busy_o, 0);
        chk("t5_post_valid", out_valid_o, 0);
        chk("t5_post_err", tag_err_o, 0);

        // Normal operation after flush
        cyc(); in_valid_i = 1'b1; tag_i = 4'd9;
        cyc(); in_valid_i = 1'b0; slice_out_valid_i = 1'b1; slice_result_i = 32'h4000_0000;
`ifdef FPNEW_HUB_RESBUF_BYPASS_EN
        out_ready_i = 1'b1; #2;
        chk("t6_byp_valid", out_valid_o, 1);
        chk("t6_byp_result", result_o, 32'h4000_0000);
        chk("t6_byp_tag", tag_o, 9);
        cyc(); slice_out_valid_i = 1'b0; out_ready_i = 1'b0; #2;
        chk("t6_byp_fifo_empty", out_valid_o, 0);
        chk("t6_byp_busy", busy_o, 0);
`else
        #2;
        chk("t6_lat_valid", out_valid_o, 0);
        cyc(); slice_out_valid_i = 1'b0; #2;
        chk("t6_valid", out_valid_o, 1);
        chk("t6_tag", tag_o, 9);
        chk("t6_result", result_o, 32'h4000_0000);
        out_ready_i = 1'b1;
        cyc(); out_ready_i = 1'b0; #2;
        chk("t6_busy", busy_o, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
